mc_mem_port: RTL

Unified single-port instruction/data memory with fixed-latency access for the multi-cycle RISC-V core. It sits directly upstream of the control unit. It holds the instruction register (IR) and the memory data register (MDR), and drives the control unit's opcode input from `IR[6:0]`. It consumes the control unit's `IorD`, `MemRead`, `MemWrite` and `IRWrite` strobes. While an access is in flight it asserts `mem_busy` so the control unit holds its current state.

---
 rtl/mc_mem_port.sv | 95 +++++++++
 1 files changed

// File: rtl/mc_mem_port.sv
// mc_mem_port: unified fixed-latency instruction/data memory with IR and MDR for the multi-cycle core
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   pc, alu_out, IorD      fetch/data address and select (IorD=1 picks alu_out)
//   MemRead, MemWrite      access requests (write wins when both are set)
//   IRWrite                load ir as well as mdr when a read completes
//   write_data             store data, latched when the request is accepted
//   mem_busy               access in flight, control unit must stall
//   ir, part_of_inst       instruction register and its opcode field ir[6:0]
//   mdr                    memory data register
//   misaligned             sticky alignment fault
// Optional feature: define MEM_ALIGN_CHECK_EN to reject addresses with addr[1:0]!=0.
module mc_mem_port #(
    parameter int MEM_DEPTH = 16384,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    input  logic        IorD,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        IRWrite,
    input  logic [31:0] write_data,
    output logic        mem_busy,
    output logic [31:0] ir,
    output logic [6:0]  part_of_inst,
    output logic [31:0] mdr,
    output logic        misaligned
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = $clog2(LATENCY + 1) < 2 ? 2 : $clog2(LATENCY + 1);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d, ir_q, ir_d, mdr_q, mdr_d;
    logic          we_q, we_d, irw_q, irw_d, mis_q, mis_d;
    logic [31:0]   addr;
    logic          req, bad, start, done, unused_addr_bits;
    logic [31:0]   mem [MEM_DEPTH];
    always_comb begin
        addr    = IorD ? alu_out : pc;
        req     = MemRead | MemWrite;
`ifdef MEM_ALIGN_CHECK_EN
        bad     = |addr[1:0];
`else
        bad     = 1'b0;
`endif
        start   = state_q == IDLE && req && !bad;
        done    = state_q == ACCESS && cnt_q == '0;
        state_d = start ? ACCESS : done ? IDLE : state_q;
        cnt_d   = start ? CW'(LATENCY - 1) : (state_q == ACCESS && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        idx_d   = start ? addr[AW+1:2] : idx_q;
        wdata_d = start ? write_data : wdata_q;
        we_d    = start ? MemWrite : we_q;
        irw_d   = start ? IRWrite : irw_q;
        mdr_d   = (done && !we_q) ? mem[idx_q] : mdr_q;
        ir_d    = (done && !we_q && irw_q) ? mem[idx_q] : ir_q;
        mis_d   = mis_q | (state_q == IDLE && req && bad);
        // Gated by reset so the control unit never sees a stall while reset is held.
        mem_busy = !reset && ((state_q == IDLE && req) || (state_q == ACCESS && cnt_q != '0));
        unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            mis_q   <= mis_d;
        end
    end
    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        we_q    <= we_d;
        irw_q   <= irw_d;
    end
    // Reset on the completion edge aborts the store.
    always_ff @(posedge clk) begin
        if (!reset && done && we_q) mem[idx_q] <= wdata_q;
    end
    assign ir           = ir_q;
    assign part_of_inst = ir_q[6:0];
    assign mdr          = mdr_q;
    assign misaligned   = mis_q;
endmodule
